// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, one write port, two registered read ports
// Optional write-to-read bypass, optional hardwired zero register, synchronous bulk clear.
module regfile_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_enable,
  input  logic [AW-1:0]    wa_reg,
  input  logic [WIDTH-1:0] wd_reg,
  input  logic             r_enable,
  input  logic [AW-1:0]    ra_reg1,
  input  logic [AW-1:0]    ra_reg2,
  input  logic             clr,
  output logic [WIDTH-1:0] rd_reg1,
  output logic [WIDTH-1:0] rd_reg2,
  output logic             rd_valid,
  output logic             w_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_legal;
  logic             w_drop;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;

  // An address is usable when it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w_legal = w_enable && !clr && addr_ok(wa_reg);
    w_drop  = w_enable && !clr && !addr_ok(wa_reg);
    rdata1  = '0;
    rdata2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra_reg1 == AW'(i)) rdata1 = mem[i];
      if (ra_reg2 == AW'(i)) rdata2 = mem[i];
    end
    if ((BYPASS != 0) && w_legal && (wa_reg == ra_reg1)) rdata1 = wd_reg;
    if ((BYPASS != 0) && w_legal && (wa_reg == ra_reg2)) rdata2 = wd_reg;
    // Clear, out-of-range and zero-register reads override everything, bypass included.
    if (clr || !addr_ok(ra_reg1)) rdata1 = '0;
    if (clr || !addr_ok(ra_reg2)) rdata2 = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_reg1  <= '0;
      rd_reg2  <= '0;
      rd_valid <= 1'b0;
      w_err    <= 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (w_legal) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wa_reg == AW'(i)) mem[i] <= wd_reg;
        end
      end
      if (r_enable) begin
        rd_reg1 <= rdata1;
        rd_reg2 <= rdata2;
      end
      rd_valid <= r_enable;
      w_err    <= w_drop;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
// Three instances share stimulus: a (bypass), b (no bypass), c (DEPTH=3, zero register).
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_enable = 1'b0;
  logic [1:0] wa_reg = '0;
  logic [3:0] wd_reg = '0;
  logic       r_enable = 1'b0;
  logic [1:0] ra_reg1 = '0;
  logic [1:0] ra_reg2 = '0;
  logic       clr = 1'b0;

  logic [3:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic       a_v, a_e, b_v, b_e, c_v, c_e;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(4), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .w_enable(w_enable), .wa_reg(wa_reg), .wd_reg(wd_reg),
    .r_enable(r_enable), .ra_reg1(ra_reg1), .ra_reg2(ra_reg2), .clr(clr),
    .rd_reg1(a_rd1), .rd_reg2(a_rd2), .rd_valid(a_v), .w_err(a_e));

  regfile_param #(.WIDTH(4), .DEPTH(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .w_enable(w_enable), .wa_reg(wa_reg), .wd_reg(wd_reg),
    .r_enable(r_enable), .ra_reg1(ra_reg1), .ra_reg2(ra_reg2), .clr(clr),
    .rd_reg1(b_rd1), .rd_reg2(b_rd2), .rd_valid(b_v), .w_err(b_e));

  regfile_param #(.WIDTH(4), .DEPTH(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .w_enable(w_enable), .wa_reg(wa_reg), .wd_reg(wd_reg),
    .r_enable(r_enable), .ra_reg1(ra_reg1), .ra_reg2(ra_reg2), .clr(clr),
    .rd_reg1(c_rd1), .rd_reg2(c_rd2), .rd_valid(c_v), .w_err(c_e));

  // Apply one cycle of stimulus, then sample just after the rising edge.
  task automatic drive(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                       input logic re, input logic [1:0] r1, input logic [1:0] r2,
                       input logic c);
    w_enable = we; wa_reg = wa; wd_reg = wd;
    r_enable = re; ra_reg1 = r1; ra_reg2 = r2; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    total++; if (a_rd1 !== 4'h0) $display("FAIL reset_rd1 got %h want %h", a_rd1, 4'h0); else passed++;
    total++; if (a_v !== 1'b0) $display("FAIL reset_valid got %b want %b", a_v, 1'b0); else passed++;
    total++; if (c_e !== 1'b0) $display("FAIL reset_werr got %b want %b", c_e, 1'b0); else passed++;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 2'd1, 4'hA, 0, 2'd0, 2'd0, 0);
    drive(1, 2'd0, 4'hF, 1, 2'd1, 2'd1, 0);
    total++; if (a_rd1 !== 4'hA) $display("FAIL pre_reset_rd1 got %h want %h", a_rd1, 4'hA); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL pre_reset_valid got %b want %b", a_v, 1'b1); else passed++;
    total++; if (c_e !== 1'b1) $display("FAIL pre_reset_werr got %b want %b", c_e, 1'b1); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (a_rd1 !== 4'h0) $display("FAIL async_reset_rd1 got %h want %h", a_rd1, 4'h0); else passed++;
    total++; if (a_rd2 !== 4'h0) $display("FAIL async_reset_rd2 got %h want %h", a_rd2, 4'h0); else passed++;
    total++; if (a_v !== 1'b0) $display("FAIL async_reset_valid got %b want %b", a_v, 1'b0); else passed++;
    total++; if (c_e !== 1'b0) $display("FAIL async_reset_werr got %b want %b", c_e, 1'b0); else passed++;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 2'd0, 4'h0, 1, 2'd1, 2'd1, 0);
    total++; if (a_rd1 !== 4'h0) $display("FAIL post_reset_rd1 got %h want %h", a_rd1, 4'h0); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL post_reset_valid got %b want %b", a_v, 1'b1); else passed++;
  endtask

  task automatic test_dual_read;
    drive(1, 2'd2, 4'h5, 0, 2'd0, 2'd0, 0);
    drive(1, 2'd3, 4'hC, 0, 2'd0, 2'd0, 0);
    drive(0, 2'd0, 4'h0, 1, 2'd2, 2'd3, 0);
    total++; if (a_rd1 !== 4'h5) $display("FAIL dual_rd1 got %h want %h", a_rd1, 4'h5); else passed++;
    total++; if (a_rd2 !== 4'hC) $display("FAIL dual_rd2 got %h want %h", a_rd2, 4'hC); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL dual_valid got %b want %b", a_v, 1'b1); else passed++;
    total++; if (c_rd2 !== 4'h0) $display("FAIL dual_range_rd2 got %h want %h", c_rd2, 4'h0); else passed++;
    drive(0, 2'd0, 4'h0, 0, 2'd0, 2'd0, 0);
    total++; if (a_v !== 1'b0) $display("FAIL dual_valid_pulse got %b want %b", a_v, 1'b0); else passed++;
  endtask

  task automatic test_same_edge;
    drive(1, 2'd1, 4'h3, 0, 2'd0, 2'd0, 0);
    drive(1, 2'd1, 4'h9, 1, 2'd1, 2'd1, 0);
    total++; if (a_rd1 !== 4'h9) $display("FAIL bypass_rd1 got %h want %h", a_rd1, 4'h9); else passed++;
    total++; if (b_rd1 !== 4'h3) $display("FAIL nobypass_rd1 got %h want %h", b_rd1, 4'h3); else passed++;
    total++; if (b_rd2 !== 4'h3) $display("FAIL nobypass_rd2 got %h want %h", b_rd2, 4'h3); else passed++;
    total++; if (c_rd1 !== 4'h9) $display("FAIL bypass_c_rd1 got %h want %h", c_rd1, 4'h9); else passed++;
    drive(0, 2'd0, 4'h0, 1, 2'd1, 2'd0, 0);
    total++; if (b_rd1 !== 4'h9) $display("FAIL nobypass_next_rd1 got %h want %h", b_rd1, 4'h9); else passed++;
  endtask

  task automatic test_zero_range;
    drive(1, 2'd0, 4'hF, 0, 2'd0, 2'd0, 0);
    total++; if (c_e !== 1'b1) $display("FAIL zero_werr got %b want %b", c_e, 1'b1); else passed++;
    total++; if (a_e !== 1'b0) $display("FAIL legal_werr got %b want %b", a_e, 1'b0); else passed++;
    drive(0, 2'd0, 4'h0, 0, 2'd0, 2'd0, 0);
    total++; if (c_e !== 1'b0) $display("FAIL zero_werr_pulse got %b want %b", c_e, 1'b0); else passed++;
    drive(0, 2'd0, 4'h0, 1, 2'd0, 2'd1, 0);
    total++; if (c_rd1 !== 4'h0) $display("FAIL zero_read got %h want %h", c_rd1, 4'h0); else passed++;
    total++; if (a_rd1 !== 4'hF) $display("FAIL reg0_read got %h want %h", a_rd1, 4'hF); else passed++;
    total++; if (c_rd2 !== 4'h9) $display("FAIL c_reg1_read got %h want %h", c_rd2, 4'h9); else passed++;
    drive(1, 2'd3, 4'h6, 0, 2'd0, 2'd0, 0);
    total++; if (c_e !== 1'b1) $display("FAIL range_werr got %b want %b", c_e, 1'b1); else passed++;
    drive(0, 2'd0, 4'h0, 1, 2'd3, 2'd2, 0);
    total++; if (c_rd1 !== 4'h0) $display("FAIL range_read got %h want %h", c_rd1, 4'h0); else passed++;
    total++; if (c_rd2 !== 4'h5) $display("FAIL range_unchanged got %h want %h", c_rd2, 4'h5); else passed++;
    total++; if (a_rd1 !== 4'h6) $display("FAIL reg3_read got %h want %h", a_rd1, 4'h6); else passed++;
    total++; if (c_e !== 1'b0) $display("FAIL read_no_werr got %b want %b", c_e, 1'b0); else passed++;
  endtask

  task automatic test_clear;
    drive(1, 2'd2, 4'h7, 1, 2'd2, 2'd2, 1);
    total++; if (a_rd2 !== 4'h0) $display("FAIL clr_rd2 got %h want %h", a_rd2, 4'h0); else passed++;
    total++; if (b_rd2 !== 4'h0) $display("FAIL clr_b_rd2 got %h want %h", b_rd2, 4'h0); else passed++;
    total++; if (a_e !== 1'b0) $display("FAIL clr_werr got %b want %b", a_e, 1'b0); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL clr_valid got %b want %b", a_v, 1'b1); else passed++;
    drive(0, 2'd0, 4'h0, 1, 2'd2, 2'd3, 0);
    total++; if (a_rd1 !== 4'h0) $display("FAIL clr_reg2 got %h want %h", a_rd1, 4'h0); else passed++;
    total++; if (a_rd2 !== 4'h0) $display("FAIL clr_reg3 got %h want %h", a_rd2, 4'h0); else passed++;
    drive(0, 2'd0, 4'h0, 1, 2'd0, 2'd1, 0);
    total++; if (a_rd1 !== 4'h0) $display("FAIL clr_reg0 got %h want %h", a_rd1, 4'h0); else passed++;
    total++; if (a_rd2 !== 4'h0) $display("FAIL clr_reg1 got %h want %h", a_rd2, 4'h0); else passed++;
  endtask

  task automatic test_hold;
    drive(1, 2'd1, 4'h4, 0, 2'd0, 2'd0, 0);
    drive(1, 2'd3, 4'h8, 0, 2'd0, 2'd0, 0);
    drive(0, 2'd0, 4'h0, 1, 2'd1, 2'd3, 0);
    total++; if (a_rd2 !== 4'h8) $display("FAIL hold_setup_rd2 got %h want %h", a_rd2, 4'h8); else passed++;
    for (int k = 1; k <= 3; k++) begin
      drive(1, 2'd1, 4'(k), 0, 2'd2, 2'd2, 0);
      total++; if (a_rd1 !== 4'h4) $display("FAIL hold_rd1 cyc%0d got %h want %h", k, a_rd1, 4'h4); else passed++;
      total++; if (a_rd2 !== 4'h8) $display("FAIL hold_rd2 cyc%0d got %h want %h", k, a_rd2, 4'h8); else passed++;
      total++; if (a_v !== 1'b0) $display("FAIL hold_valid cyc%0d got %b want %b", k, a_v, 1'b0); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 2'd0, 4'h0, 1, 2'd1, 2'd3, 0);
    total++; if (b_rd1 !== 4'h3) $display("FAIL b2b_rd1 got %h want %h", b_rd1, 4'h3); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL b2b_valid0 got %b want %b", a_v, 1'b1); else passed++;
    drive(1, 2'd2, 4'hD, 1, 2'd2, 2'd1, 0);
    total++; if (a_rd1 !== 4'hD) $display("FAIL b2b_bypass got %h want %h", a_rd1, 4'hD); else passed++;
    total++; if (b_rd1 !== 4'h0) $display("FAIL b2b_nobypass got %h want %h", b_rd1, 4'h0); else passed++;
    total++; if (a_rd2 !== 4'h3) $display("FAIL b2b_rd2 got %h want %h", a_rd2, 4'h3); else passed++;
    total++; if (a_v !== 1'b1) $display("FAIL b2b_valid1 got %b want %b", a_v, 1'b1); else passed++;
    drive(0, 2'd0, 4'h0, 0, 2'd0, 2'd0, 0);
    total++; if (a_v !== 1'b0) $display("FAIL b2b_valid_end got %b want %b", a_v, 1'b0); else passed++;
  endtask

  initial begin
    test_reset();
    test_dual_read();
    test_same_edge();
    test_zero_range();
    test_clear();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
